// File: rtl/rca_accumulator_pkg.sv
// Shared constants for the ripple-carry burst accumulator: default widths and
// the FSM state encoding.
package rca_accumulator_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage : rca_accumulator_pkg

// File: rtl/rca_accumulator_if.sv
// Burst control, operand stream and result handshake of the accumulator.
// The master drives requests and operands; the slave is the accumulator.
interface rca_accumulator_if
  import rca_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
  );

endinterface : rca_accumulator_if

// File: rtl/RCA.sv
// Ripple-carry adder built from a chain of full-adder cells, one per bit.
module RCA #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  // NOTE: blocking assignments are correct here; carry must ripple bit by bit
  // within the same evaluation, and every output gets a value on every path.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign cout = carry;

endmodule : RCA

// File: rtl/rca_accumulator.sv
// Burst accumulator: sums len operands through a single ripple-carry adder and
// presents the wrapped sum with a sticky carry flag until the consumer takes it.
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  rca_accumulator_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  RCA #(.WIDTH(WIDTH)) u_rca (
    .a    (acc_q),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: every next-state signal defaults to its current value first, so no
  // branch of the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_cout;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;

endmodule : rca_accumulator

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: hand-computed bursts, wrap-around, a
// zero-length burst under backpressure, and reset in the middle of a burst.
module tb_rca_accumulator;
  import rca_accumulator_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rca_accumulator_if #(.WIDTH(32), .CNT_W(8)) bus ();

  rca_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    step();
    bus.start = 1'b0;
    bus.len   = 8'd0;
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum",   bus.out_sum,        32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic sum 5 + 2; start held high on the final handshake must be ignored
    start_burst(8'd2);
    check("b1_in_ready", 32'(bus.in_ready), 32'd1);
    check("b1_busy",     32'(bus.busy),     32'd1);
    send(32'h0000_0005);
    check("b1_mid_valid", 32'(bus.out_valid), 32'd0);
    check("b1_mid_sum",   bus.out_sum,        32'h0000_0005);
    bus.start = 1'b1;
    bus.len   = 8'd9;
    send(32'h0000_0002);
    bus.start = 1'b0;
    bus.len   = 8'd0;
    check("b1_out_valid", 32'(bus.out_valid), 32'd1);
    check("b1_sum",       bus.out_sum,        32'h0000_0007);
    check("b1_carry",     32'(bus.out_carry), 32'd0);
    check("b1_in_ready",  32'(bus.in_ready),  32'd0);
    consume();
    check("b1_after_valid", 32'(bus.out_valid), 32'd0);
    check("b1_after_busy",  32'(bus.busy),      32'd0);

    // Wider sum with a two-cycle in_valid gap
    start_burst(8'd2);
    send(32'h0000_000F);
    step();
    check("b2_gap_ready", 32'(bus.in_ready), 32'd1);
    check("b2_gap_sum",   bus.out_sum,       32'h0000_000F);
    step();
    check("b2_gap_valid", 32'(bus.out_valid), 32'd0);
    send(32'h0000_FFFF);
    check("b2_valid", 32'(bus.out_valid), 32'd1);
    check("b2_sum",   bus.out_sum,        32'h0001_000E);
    check("b2_carry", 32'(bus.out_carry), 32'd0);
    consume();

    // Overflow wrap with sticky carry
    start_burst(8'd3);
    send(32'hFFFF_FFFF);
    check("b3_sum1",   bus.out_sum,        32'hFFFF_FFFF);
    check("b3_carry1", 32'(bus.out_carry), 32'd0);
    send(32'h0000_0002);
    check("b3_sum2",   bus.out_sum,        32'h0000_0001);
    check("b3_carry2", 32'(bus.out_carry), 32'd1);
    send(32'h1000_0FFF);
    check("b3_valid", 32'(bus.out_valid), 32'd1);
    check("b3_sum",   bus.out_sum,        32'h1000_1000);
    check("b3_carry", 32'(bus.out_carry), 32'd1);
    consume();

    // Zero-length burst, backpressure, start ignored in DONE
    start_burst(8'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      check("b4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("b4_hold_sum",   bus.out_sum,        32'd0);
      check("b4_hold_carry", 32'(bus.out_carry), 32'd0);
      check("b4_hold_ready", 32'(bus.in_ready),  32'd0);
      bus.start = (i == 2);
      bus.len   = 8'd3;
      step();
    end
    check("b4_still_valid", 32'(bus.out_valid), 32'd1);
    check("b4_still_sum",   bus.out_sum,        32'd0);
    bus.start = 1'b1;
    consume();
    bus.start    = 1'b0;
    bus.len      = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("b4_idle_valid", 32'(bus.out_valid), 32'd0);
    check("b4_idle_busy",  32'(bus.busy),      32'd0);
    step();
    check("b4_idle_busy2", 32'(bus.busy), 32'd0);

    // Reset mid-burst, then a fresh single-operand burst
    start_burst(8'd4);
    send(32'hFFFF_FFFF);
    send(32'h0000_0003);
    check("b5_pre_sum",   bus.out_sum,        32'h0000_0002);
    check("b5_pre_carry", 32'(bus.out_carry), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("b5_rst_busy",  32'(bus.busy),      32'd0);
    check("b5_rst_ready", 32'(bus.in_ready),  32'd0);
    check("b5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("b5_rst_sum",   bus.out_sum,        32'd0);
    check("b5_rst_carry", 32'(bus.out_carry), 32'd0);
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0040;
    step();
    step();
    check("b5_nostart_ready", 32'(bus.in_ready), 32'd0);
    check("b5_nostart_sum",   bus.out_sum,       32'd0);
    bus.in_valid = 1'b0;
    start_burst(8'd1);
    send(32'h0000_0008);
    check("b5_valid", 32'(bus.out_valid), 32'd1);
    check("b5_sum",   bus.out_sum,        32'h0000_0008);
    check("b5_carry", 32'(bus.out_carry), 32'd0);
    consume();
    check("b5_done_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca_accumulator

// File: doc/rca_accumulator.md
RCA_ACCUMULATOR -- requirements
Module: rca_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and accumulator width.
REQ-002 SHALL have parameter CNT_W, default 8: width of the burst-length input.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port len, input, CNT_W: number of operands in the burst; sampled with start.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_data, input, WIDTH: operand to accumulate.
REQ-009 SHALL have port in_ready, output, 1: block accepts an operand.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_sum, output, WIDTH: accumulated sum, modulo 2^WIDTH.
REQ-012 SHALL have port out_carry, output, 1: sticky flag; set if any addition in the burst produced a carry-out.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port busy, output, 1: asserted in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-016 In IDLE, start=1 with len>0 SHALL clear acc and the sticky carry, load the counter with len, and go to ACCUM.
REQ-017 In IDLE, start=1 with len=0 SHALL clear acc and the sticky carry and go directly to DONE.
REQ-018 In IDLE, the block SHALL hold its state while start=0.
REQ-019 In ACCUM, in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and DONE.
REQ-020 On each handshake (in_valid and in_ready), the block SHALL:
- update acc to acc + in_data, computed by the ripple-carry adder with cin=0;
- OR the adder carry-out into the sticky carry;
- decrement the counter.
REQ-021 A handshake while the counter equals 1 SHALL move the FSM to DONE on the same edge.
REQ-022 Cycles with in_valid=0 in ACCUM SHALL leave acc, the counter and the sticky carry unchanged.
REQ-023 In DONE, out_valid SHALL be 1 and out_sum/out_carry SHALL hold stable until out_ready=1.
REQ-024 out_ready=1 in DONE SHALL return the FSM to IDLE on the next edge; out_valid SHALL deassert that edge.
REQ-025 Latency: out_valid SHALL assert in the first cycle after the final operand handshake.
REQ-026 start SHALL be ignored in ACCUM and DONE, including when it coincides with the final handshake or with out_ready.
REQ-027 out_sum SHALL continuously reflect the acc register; its value is meaningful only while out_valid=1.
REQ-028 Addition SHALL wrap modulo 2^WIDTH with no saturation; overflow is reported only through out_carry.

Reset
REQ-029 Asserting rst_n=0 SHALL, asynchronously and at any point including mid-burst:
- force state to IDLE;
- clear acc, the counter and the sticky carry to 0;
- drive in_ready, out_valid, out_carry and busy to 0.
REQ-030 After reset deasserts, the block SHALL require a new start before accepting any operand.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the default WIDTH and CNT_W constants.
REQ-032 The adder SHALL be the existing 32-bit ripple-carry adder module RCA, instantiated once as a sub-module with cin tied to 0.
REQ-033 No other adder SHALL be inferred.
REQ-034 The FSM, counter, acc and sticky-carry registers SHALL live in rca_accumulator.

Verification
REQ-035 Basic sum: start with len=2, operands 0x00000005 then 0x00000002 -> out_sum=0x00000007, out_carry=0, out_valid asserts one cycle after the second handshake.
REQ-036 Wider sum: len=2, operands 0x0000000F and 0x0000FFFF, with a two-cycle in_valid gap between them -> out_sum=0x0001000E, out_carry=0.
REQ-037 Overflow wrap: len=3, operands 0xFFFFFFFF, 0x00000002, 0x10000FFF -> out_sum=0x10001000, out_carry=1 (sticky from the second add).
REQ-038 Zero-length burst and backpressure: len=0 -> DONE with out_sum=0 and no in_ready; hold out_ready=0 for 5 cycles -> out_valid and out_sum stable, and a start pulse in DONE is ignored.
REQ-039 Reset mid-burst: len=4, assert rst_n=0 after 2 handshakes -> immediate IDLE, all outputs 0; a fresh burst of len=1 with 0x00000008 -> out_sum=0x00000008.
